// File: rtl/rob_tag_queue_if.sv
// Reorder-buffer tag queue bus: allocate, writeback, operand lookup, commit and flush.
// Combinational lookup/commit outputs; allocation is backpressured by alloc_ready.
interface rob_tag_queue_if #(
    parameter int DATA_W = 32
);
    logic              alloc_req;
    logic [4:0]        alloc_dest;
    logic              alloc_ready;
    logic [3:0]        alloc_tag;
    logic              wb_valid;
    logic [3:0]        wb_tag;
    logic [DATA_W-1:0] wb_value;
    logic [3:0]        rd_tag_a;
    logic [3:0]        rd_tag_b;
    logic              rd_ready_a;
    logic              rd_ready_b;
    logic [DATA_W-1:0] rd_value_a;
    logic [DATA_W-1:0] rd_value_b;
    logic              commit_valid;
    logic [4:0]        commit_dest;
    logic [DATA_W-1:0] commit_value;
    logic [3:0]        commit_tag;
    logic              commit_we;
    logic [3:0]        status_tag;
    logic              status_clear;
    logic              flush;
    logic [3:0]        count;

    modport slave (
        input  alloc_req, alloc_dest, wb_valid, wb_tag, wb_value,
               rd_tag_a, rd_tag_b, status_tag, flush,
        output alloc_ready, alloc_tag, rd_ready_a, rd_ready_b, rd_value_a, rd_value_b,
               commit_valid, commit_dest, commit_value, commit_tag, commit_we,
               status_clear, count
    );

    modport master (
        output alloc_req, alloc_dest, wb_valid, wb_tag, wb_value,
               rd_tag_a, rd_tag_b, status_tag, flush,
        input  alloc_ready, alloc_tag, rd_ready_a, rd_ready_b, rd_value_a, rd_value_b,
               commit_valid, commit_dest, commit_value, commit_tag, commit_we,
               status_clear, count
    );
endinterface

// File: rtl/rob_tag_queue.sv
// 15-entry in-order ROB, tags 1..15; commit is combinational off the head, wb-to-commit 1 cycle; alloc stalls when full.
// ROB_WB_BYPASS_EN forwards a same-cycle writeback onto the operand lookup ports.
module rob_tag_queue #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    rob_tag_queue_if.slave bus
);
    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] val;
    } rd_t;

    // State is addressed by tag (1..15); index = tag-1 lives only in the pointers.
    logic [15:1]       r_busy;
    logic [15:1]       r_done;
    logic [4:0]        r_dest  [1:15];
    logic [DATA_W-1:0] r_value [1:15];
    logic [3:0]        r_head;
    logic [3:0]        r_tail;
    logic [3:0]        r_count;

    logic [15:0] w_busy_t;
    logic [15:0] w_done_t;
    logic [3:0]  w_head_tag;
    logic [3:0]  w_tail_tag;
    logic        w_alloc_ready;
    logic        w_alloc;
    logic        w_wb;
    logic        w_commit;
    logic        w_commit_we;
    rd_t         w_rd_a;
    rd_t         w_rd_b;

    function automatic logic [3:0] ptr_next(input logic [3:0] p);
        return (p == 4'd14) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic rd_t lookup(input logic [3:0] tag);
        rd_t r;
        r.rdy = w_busy_t[tag] && w_done_t[tag];
        r.val = r.rdy ? r_value[tag] : '0;
`ifdef ROB_WB_BYPASS_EN
        if (bus.wb_valid && (bus.wb_tag == tag) && (tag != 4'd0) && w_busy_t[tag]) begin
            r.rdy = 1'b1;
            r.val = bus.wb_value;
        end
`endif
        return r;
    endfunction

    assign w_busy_t      = {r_busy, 1'b0};
    assign w_done_t      = {r_done, 1'b0};
    assign w_head_tag    = r_head + 4'd1;
    assign w_tail_tag    = r_tail + 4'd1;
    assign w_alloc_ready = (r_count != 4'd15);
    assign w_alloc       = bus.alloc_req && w_alloc_ready;
    assign w_wb          = bus.wb_valid && (bus.wb_tag != 4'd0) && w_busy_t[bus.wb_tag];
    assign w_commit      = !bus.flush && w_busy_t[w_head_tag] && w_done_t[w_head_tag];
    assign w_commit_we   = w_commit && (r_dest[w_head_tag] != 5'd0);
    assign w_rd_a        = lookup(bus.rd_tag_a);
    assign w_rd_b        = lookup(bus.rd_tag_b);

    assign bus.alloc_ready  = w_alloc_ready;
    assign bus.alloc_tag    = w_tail_tag;
    assign bus.rd_ready_a   = w_rd_a.rdy;
    assign bus.rd_value_a   = w_rd_a.val;
    assign bus.rd_ready_b   = w_rd_b.rdy;
    assign bus.rd_value_b   = w_rd_b.val;
    assign bus.commit_valid = w_commit;
    assign bus.commit_dest  = r_dest[w_head_tag];
    assign bus.commit_value = r_value[w_head_tag];
    assign bus.commit_tag   = w_head_tag;
    assign bus.commit_we    = w_commit_we;
    assign bus.status_clear = w_commit_we && (bus.status_tag == w_head_tag);
    assign bus.count        = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= 4'd0;
            r_tail  <= 4'd0;
            r_count <= 4'd0;
        end else if (bus.flush) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= 4'd0;
            r_tail  <= 4'd0;
            r_count <= 4'd0;
        end else begin
            if (w_wb) begin
                r_done[bus.wb_tag] <= 1'b1;
            end
            // Head and tail never coincide here: full blocks alloc, empty blocks commit.
            if (w_commit) begin
                r_busy[w_head_tag] <= 1'b0;
                r_done[w_head_tag] <= 1'b0;
                r_head             <= ptr_next(r_head);
            end
            if (w_alloc) begin
                r_busy[w_tail_tag] <= 1'b1;
                r_done[w_tail_tag] <= 1'b0;
                r_tail             <= ptr_next(r_tail);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.flush && w_alloc) begin
            r_dest[w_tail_tag] <= bus.alloc_dest;
        end
        if (!bus.flush && w_wb) begin
            r_value[bus.wb_tag] <= bus.wb_value;
        end
    end
endmodule

// File: tb/tb_rob_tag_queue.sv
// Directed bench for rob_tag_queue; expectations are hand-derived per scenario.
module tb_rob_tag_queue;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    rob_tag_queue_if #(.DATA_W(32)) bus ();

    rob_tag_queue #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_req  = 1'b0;
        bus.alloc_dest = 5'd0;
        bus.wb_valid   = 1'b0;
        bus.wb_tag     = 4'd0;
        bus.wb_value   = 32'd0;
        bus.rd_tag_a   = 4'd0;
        bus.rd_tag_b   = 4'd0;
        bus.status_tag = 4'd0;
        bus.flush      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.alloc_req  = 1'b1;
            bus.alloc_dest = 5'(i + 1);
            tick();
        end
        bus.alloc_req = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        n_vec++; if (bus.alloc_ready !== 1'b1) begin n_err++; $display("FAIL rst_alloc_ready got %0d exp 1", bus.alloc_ready); end
        n_vec++; if (bus.alloc_tag !== 4'd1) begin n_err++; $display("FAIL rst_alloc_tag got %0d exp 1", bus.alloc_tag); end
        n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", bus.count); end
        n_vec++; if ({bus.commit_valid, bus.commit_we, bus.status_clear} !== 3'b000) begin n_err++; $display("FAIL rst_commit got %b exp 000", {bus.commit_valid, bus.commit_we, bus.status_clear}); end
        n_vec++; if ({bus.rd_ready_a, bus.rd_ready_b} !== 2'b00) begin n_err++; $display("FAIL rst_rd_ready got %b exp 00", {bus.rd_ready_a, bus.rd_ready_b}); end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        do_reset();
        bus.alloc_req  = 1'b1;
        bus.alloc_dest = 5'd5;
        #1;
        n_vec++; if (bus.alloc_tag !== 4'd1) begin n_err++; $display("FAIL basic_alloc_tag got %0d exp 1", bus.alloc_tag); end
        tick();
        bus.alloc_req = 1'b0;
        bus.wb_valid  = 1'b1;
        bus.wb_tag    = 4'd1;
        bus.wb_value  = 32'hAB;
        #1;
        n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL basic_count got %0d exp 1", bus.count); end
        n_vec++; if (bus.commit_valid !== 1'b0) begin n_err++; $display("FAIL basic_wb_same_cycle_commit got %0d exp 0", bus.commit_valid); end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        n_vec++; if (bus.commit_valid !== 1'b1) begin n_err++; $display("FAIL basic_commit_valid got %0d exp 1", bus.commit_valid); end
        n_vec++; if (bus.commit_dest !== 5'd5) begin n_err++; $display("FAIL basic_commit_dest got %0d exp 5", bus.commit_dest); end
        n_vec++; if (bus.commit_value !== 32'hAB) begin n_err++; $display("FAIL basic_commit_value got %0h exp ab", bus.commit_value); end
        n_vec++; if (bus.commit_tag !== 4'd1) begin n_err++; $display("FAIL basic_commit_tag got %0d exp 1", bus.commit_tag); end
        n_vec++; if (bus.commit_we !== 1'b1) begin n_err++; $display("FAIL basic_commit_we got %0d exp 1", bus.commit_we); end
        tick();
        n_vec++; if ({bus.commit_valid, bus.count} !== 5'b0_0000) begin n_err++; $display("FAIL basic_after_commit got %b exp 00000", {bus.commit_valid, bus.count}); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            bus.alloc_req  = 1'b1;
            bus.alloc_dest = 5'(i + 1);
            #1;
            n_vec++; if (bus.alloc_tag !== 4'(i + 1)) begin n_err++; $display("FAIL full_alloc_tag got %0d exp %0d", bus.alloc_tag, i + 1); end
            tick();
        end
        bus.alloc_req = 1'b0;
        #1;
        n_vec++; if (bus.count !== 4'd15) begin n_err++; $display("FAIL full_count got %0d exp 15", bus.count); end
        n_vec++; if (bus.alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_alloc_ready got %0d exp 0", bus.alloc_ready); end
        bus.alloc_req = 1'b1;
        tick();
        bus.alloc_req = 1'b0;
        bus.wb_valid  = 1'b1;
        bus.wb_tag    = 4'd1;
        bus.wb_value  = 32'h77;
        #1;
        n_vec++; if (bus.count !== 4'd15) begin n_err++; $display("FAIL full_refused_16th got %0d exp 15", bus.count); end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        n_vec++; if (bus.commit_valid !== 1'b1) begin n_err++; $display("FAIL full_commit_valid got %0d exp 1", bus.commit_valid); end
        n_vec++; if (bus.alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_during_commit got %0d exp 0", bus.alloc_ready); end
        tick();
        n_vec++; if ({bus.count, bus.alloc_ready} !== {4'd14, 1'b1}) begin n_err++; $display("FAIL full_after_commit got cnt %0d rdy %0d exp cnt 14 rdy 1", bus.count, bus.alloc_ready); end
        n_vec++; if (bus.alloc_tag !== 4'd1) begin n_err++; $display("FAIL full_wrap_tag got %0d exp 1", bus.alloc_tag); end
        bus.alloc_req  = 1'b1;
        bus.alloc_dest = 5'd9;
        tick();
        bus.alloc_req = 1'b0;
        #1;
        n_vec++; if ({bus.count, bus.alloc_tag} !== {4'd15, 4'd2}) begin n_err++; $display("FAIL full_realloc got cnt %0d tag %0d exp cnt 15 tag 2", bus.count, bus.alloc_tag); end
    endtask

    task automatic test_order();
        do_reset();
        alloc_n(2);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 4'd2;
        bus.wb_value = 32'h22;
        tick();
        bus.wb_valid = 1'b0;
        bus.rd_tag_b = 4'd2;
        #1;
        n_vec++; if (bus.commit_valid !== 1'b0) begin n_err++; $display("FAIL order_no_early_commit got %0d exp 0", bus.commit_valid); end
        n_vec++; if ({bus.rd_ready_b, bus.rd_value_b} !== {1'b1, 32'h22}) begin n_err++; $display("FAIL order_rd_b got %0d/%0h exp 1/22", bus.rd_ready_b, bus.rd_value_b); end
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 4'd1;
        bus.wb_value = 32'h11;
        #1;
        n_vec++; if (bus.commit_valid !== 1'b0) begin n_err++; $display("FAIL order_still_waiting got %0d exp 0", bus.commit_valid); end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        n_vec++; if ({bus.commit_valid, bus.commit_tag, bus.commit_value} !== {1'b1, 4'd1, 32'h11}) begin n_err++; $display("FAIL order_commit1 got v%0d t%0d %0h exp v1 t1 11", bus.commit_valid, bus.commit_tag, bus.commit_value); end
        tick();
        n_vec++; if ({bus.commit_valid, bus.commit_tag, bus.commit_value} !== {1'b1, 4'd2, 32'h22}) begin n_err++; $display("FAIL order_commit2 got v%0d t%0d %0h exp v1 t2 22", bus.commit_valid, bus.commit_tag, bus.commit_value); end
        tick();
        n_vec++; if ({bus.commit_valid, bus.count} !== 5'b0_0000) begin n_err++; $display("FAIL order_drained got %b exp 00000", {bus.commit_valid, bus.count}); end
    endtask

    task automatic test_status();
        logic [4:0] dests [5];
        dests = '{5'd4, 5'd6, 5'd7, 5'd7, 5'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.alloc_req  = 1'b1;
            bus.alloc_dest = dests[i];
            tick();
        end
        bus.alloc_req = 1'b0;
        for (int t = 5; t >= 1; t--) begin
            bus.wb_valid = 1'b1;
            bus.wb_tag   = 4'(t);
            bus.wb_value = 32'(16 + t);
            tick();
        end
        bus.wb_valid = 1'b0;
        bus.status_tag = 4'd1;
        #1;
        n_vec++; if (bus.commit_tag !== 4'd1 || bus.commit_valid !== 1'b1) begin n_err++; $display("FAIL status_first got v%0d t%0d exp v1 t1", bus.commit_valid, bus.commit_tag); end
        tick();
        tick();
        bus.status_tag = 4'd3;
        #1;
        n_vec++; if ({bus.commit_valid, bus.commit_dest, bus.commit_we, bus.status_clear} !== {1'b1, 5'd7, 1'b1, 1'b1}) begin n_err++; $display("FAIL status_match got v%0d d%0d we%0d clr%0d exp v1 d7 we1 clr1", bus.commit_valid, bus.commit_dest, bus.commit_we, bus.status_clear); end
        tick();
        bus.status_tag = 4'd9;
        #1;
        n_vec++; if ({bus.commit_tag, bus.commit_we, bus.status_clear} !== {4'd4, 1'b1, 1'b0}) begin n_err++; $display("FAIL status_nomatch got t%0d we%0d clr%0d exp t4 we1 clr0", bus.commit_tag, bus.commit_we, bus.status_clear); end
        tick();
        bus.status_tag = 4'd5;
        #1;
        n_vec++; if ({bus.commit_valid, bus.commit_we, bus.status_clear} !== 3'b100) begin n_err++; $display("FAIL status_dest0 got %b exp 100", {bus.commit_valid, bus.commit_we, bus.status_clear}); end
        tick();
        n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL status_drained got %0d exp 0", bus.count); end
    endtask

    task automatic test_bypass();
        logic        exp_rdy;
        logic [31:0] exp_val;
`ifdef ROB_WB_BYPASS_EN
        exp_rdy = 1'b1;
        exp_val = 32'h55;
`else
        exp_rdy = 1'b0;
        exp_val = 32'h0;
`endif
        do_reset();
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 4'd1;
        bus.wb_value = 32'h99;
        tick();
        bus.wb_valid = 1'b0;
        alloc_n(2);
        bus.rd_tag_a = 4'd1;
        #1;
        n_vec++; if (bus.rd_ready_a !== 1'b0) begin n_err++; $display("FAIL byp_stale_wb_ignored got %0d exp 0", bus.rd_ready_a); end
        bus.rd_tag_a = 4'd2;
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 4'd2;
        bus.wb_value = 32'h55;
        #1;
        n_vec++; if ({bus.rd_ready_a, bus.rd_value_a} !== {exp_rdy, exp_val}) begin n_err++; $display("FAIL byp_same_cycle got %0d/%0h exp %0d/%0h", bus.rd_ready_a, bus.rd_value_a, exp_rdy, exp_val); end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        n_vec++; if ({bus.rd_ready_a, bus.rd_value_a} !== {1'b1, 32'h55}) begin n_err++; $display("FAIL byp_next_cycle got %0d/%0h exp 1/55", bus.rd_ready_a, bus.rd_value_a); end
        bus.rd_tag_a = 4'd0;
        #1;
        n_vec++; if ({bus.rd_ready_a, bus.rd_value_a} !== 33'd0) begin n_err++; $display("FAIL byp_tag0 got %0d/%0h exp 0/0", bus.rd_ready_a, bus.rd_value_a); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(4);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 4'd1;
        bus.wb_value = 32'h1;
        tick();
        bus.wb_valid   = 1'b0;
        bus.flush      = 1'b1;
        bus.alloc_req  = 1'b1;
        bus.alloc_dest = 5'd3;
        #1;
        n_vec++; if (bus.commit_valid !== 1'b0) begin n_err++; $display("FAIL flush_commit_forced got %0d exp 0", bus.commit_valid); end
        tick();
        bus.flush     = 1'b0;
        bus.alloc_req = 1'b0;
        bus.rd_tag_a  = 4'd1;
        #1;
        n_vec++; if ({bus.count, bus.alloc_tag} !== {4'd0, 4'd1}) begin n_err++; $display("FAIL flush_state got cnt %0d tag %0d exp cnt 0 tag 1", bus.count, bus.alloc_tag); end
        n_vec++; if ({bus.commit_valid, bus.rd_ready_a} !== 2'b00) begin n_err++; $display("FAIL flush_no_commit got %b exp 00", {bus.commit_valid, bus.rd_ready_a}); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        alloc_n(2);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 4'd1;
        bus.wb_value = 32'h3;
        tick();
        bus.wb_valid = 1'b0;
        #1;
        n_vec++; if (bus.commit_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %0d exp 1", bus.commit_valid); end
        rst = 1'b1;
        #1;
        n_vec++; if ({bus.commit_valid, bus.count, bus.alloc_tag} !== {1'b0, 4'd0, 4'd1}) begin n_err++; $display("FAIL rstmid_async got v%0d cnt %0d tag %0d exp v0 cnt 0 tag 1", bus.commit_valid, bus.count, bus.alloc_tag); end
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_order();
        test_status();
        test_bypass();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
